// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED driver (off / PWM dim / blink / breathe)
// Optional breathe mode: define LED_PATTERN_BREATHE_EN; otherwise mode 11 behaves as DIM.
module led_pattern_gen #(
  parameter int CHANNELS    = 4,
  parameter int PRESCALE    = 16000,
  parameter int DW          = 8,
  parameter int BLINK_TICKS = 500
) (
  input  logic                   pin3_clk_16mhz,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [2*CHANNELS-1:0]  mode,
  input  logic [DW*CHANNELS-1:0] duty,
  output logic [CHANNELS-1:0]    led,
  output logic                   tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [DW-1:0] FULL = '1;

  typedef enum logic [1:0] {
    M_OFF     = 2'b00,
    M_DIM     = 2'b01,
    M_BLINK   = 2'b10,
    M_BREATHE = 2'b11
  } mode_t;

  logic [PW-1:0]                  pre_cnt;
  logic [DW-1:0]                  pwm_cnt;
  logic                           tick_evt;
  logic [CHANNELS-1:0][1:0]       mode_v;
  logic [CHANNELS-1:0][DW-1:0]    duty_v;
  logic [CHANNELS-1:0][1:0]       mode_q;
  logic [CHANNELS-1:0][BW-1:0]    bcnt, bcnt_nxt;
  logic [CHANNELS-1:0]            phase, phase_nxt;
  logic [CHANNELS-1:0]            led_nxt;

`ifdef LED_PATTERN_BREATHE_EN
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  logic [CHANNELS-1:0][DW-1:0]    level, level_nxt;
  logic [CHANNELS-1:0]            dir, dir_nxt;
`endif

  assign mode_v   = mode;
  assign duty_v   = duty;
  assign tick_evt = enable && (pre_cnt == PW'(PRESCALE - 1));

  function automatic logic pwm(input logic [DW-1:0] x, input logic [DW-1:0] cnt);
    return (cnt < x) || (x == FULL);
  endfunction

  // LED drive is computed from next-state phase/level so a restart shows on the very next cycle
  always_comb begin
    bcnt_nxt  = bcnt;
    phase_nxt = phase;
    led_nxt   = '0;
`ifdef LED_PATTERN_BREATHE_EN
    level_nxt = level;
    dir_nxt   = dir;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      if (mode_v[i] != mode_q[i]) begin
        bcnt_nxt[i]  = '0;
        phase_nxt[i] = 1'b1;
`ifdef LED_PATTERN_BREATHE_EN
        level_nxt[i] = '0;
        dir_nxt[i]   = DIR_UP;
`endif
      end else if (tick_evt) begin
        if (bcnt[i] == BW'(BLINK_TICKS - 1)) begin
          bcnt_nxt[i]  = '0;
          phase_nxt[i] = ~phase[i];
        end else begin
          bcnt_nxt[i] = bcnt[i] + BW'(1);
        end
`ifdef LED_PATTERN_BREATHE_EN
        if (dir[i] == DIR_UP) begin
          if (level[i] < duty_v[i]) begin
            level_nxt[i] = level[i] + DW'(1);
            if (level[i] + DW'(1) == duty_v[i]) dir_nxt[i] = DIR_DOWN;
          end else begin
            dir_nxt[i] = DIR_DOWN;
          end
        end else begin
          if (level[i] != '0) begin
            level_nxt[i] = level[i] - DW'(1);
            if (level[i] == DW'(1)) dir_nxt[i] = DIR_UP;
          end else begin
            dir_nxt[i] = DIR_UP;
          end
        end
`endif
      end

      case (mode_v[i])
        M_OFF:     led_nxt[i] = 1'b0;
        M_DIM:     led_nxt[i] = pwm(duty_v[i], pwm_cnt);
        M_BLINK:   led_nxt[i] = phase_nxt[i] & pwm(duty_v[i], pwm_cnt);
`ifdef LED_PATTERN_BREATHE_EN
        M_BREATHE: led_nxt[i] = pwm(level_nxt[i], pwm_cnt);
`else
        M_BREATHE: led_nxt[i] = pwm(duty_v[i], pwm_cnt);
`endif
        default:   led_nxt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge pin3_clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      tick    <= 1'b0;
      led     <= '0;
      mode_q  <= '0;
      bcnt    <= '0;
      phase   <= '1;
`ifdef LED_PATTERN_BREATHE_EN
      level   <= '0;
      dir     <= {CHANNELS{DIR_UP}};
`endif
    end else if (enable) begin
      pre_cnt <= tick_evt ? '0 : pre_cnt + PW'(1);
      pwm_cnt <= pwm_cnt + DW'(1);
      tick    <= tick_evt;
      led     <= led_nxt;
      mode_q  <= mode_v;
      bcnt    <= bcnt_nxt;
      phase   <= phase_nxt;
`ifdef LED_PATTERN_BREATHE_EN
      level   <= level_nxt;
      dir     <= dir_nxt;
`endif
    end else begin
      tick <= 1'b0;
      led  <= '0;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - randomized bench for led_pattern_gen against a tick-count reference model
module tb_led_pattern_gen;

  localparam int CH = 2;
  localparam int PS = 4;
  localparam int DW = 4;
  localparam int BT = 3;

  logic           pin3_clk_16mhz = 1'b0;
  logic           rst_n;
  logic           enable;
  logic [2*CH-1:0]  mode;
  logic [DW*CH-1:0] duty;
  logic [CH-1:0]  led;
  logic           tick;

  int errors = 0;
  int checks = 0;

  // Reference state: enabled cycles since reset, ticks since each channel's last mode change
  int ecnt;
  int t_since [CH];
  int pm      [CH];

  led_pattern_gen #(
    .CHANNELS(CH), .PRESCALE(PS), .DW(DW), .BLINK_TICKS(BT)
  ) dut (
    .pin3_clk_16mhz(pin3_clk_16mhz),
    .rst_n(rst_n),
    .enable(enable),
    .mode(mode),
    .duty(duty),
    .led(led),
    .tick(tick)
  );

  always #5 pin3_clk_16mhz = ~pin3_clk_16mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic pwm_m(input int x, input int c);
    return (c < x) || (x == (1 << DW) - 1);
  endfunction

  // Breathe level is a triangle wave of period 2*duty over ticks since entry
  function automatic int tri_level(input int t, input int d);
    int k;
    if (d == 0) return 0;
    k = t % (2 * d);
    return (k <= d) ? k : 2 * d - k;
  endfunction

  task automatic model_reset();
    ecnt = 0;
    for (int c = 0; c < CH; c++) begin
      t_since[c] = 0;
      pm[c]      = 0;
    end
  endtask

  // Called at a falling edge: drive inputs, predict, then check after the next rising edge
  task automatic step(input logic en_v, input logic [2*CH-1:0] m_v, input logic [DW*CH-1:0] d_v);
    logic [CH-1:0] e_led;
    logic          e_tick;
    logic          ev;
    int            md, d, pc;
    enable = en_v;
    mode   = m_v;
    duty   = d_v;
    e_led  = '0;
    e_tick = 1'b0;
    if (en_v) begin
      ev     = (ecnt % PS) == PS - 1;
      e_tick = ev;
      pc     = ecnt % (1 << DW);
      for (int c = 0; c < CH; c++) begin
        md = int'(m_v[2*c +: 2]);
        d  = int'(d_v[DW*c +: DW]);
        if (md != pm[c]) t_since[c] = 0;
        else if (ev) t_since[c]++;
        pm[c] = md;
        case (md)
          1: e_led[c] = pwm_m(d, pc);
          2: e_led[c] = (((t_since[c] / BT) % 2) == 0) && pwm_m(d, pc);
`ifdef LED_PATTERN_BREATHE_EN
          3: e_led[c] = pwm_m(tri_level(t_since[c], d), pc);
`else
          3: e_led[c] = pwm_m(d, pc);
`endif
          default: e_led[c] = 1'b0;
        endcase
      end
      ecnt++;
    end
    @(posedge pin3_clk_16mhz);
    @(negedge pin3_clk_16mhz);
    check("led", 32'(led), 32'(e_led));
    check("tick", 32'(tick), 32'(e_tick));
  endtask

  task automatic run(input int n, input logic en_v, input logic [2*CH-1:0] m_v,
                     input logic [DW*CH-1:0] d_v);
    for (int k = 0; k < n; k++) step(en_v, m_v, d_v);
  endtask

  int            tick_cnt;
  logic [2*CH-1:0] rm;
  logic [DW*CH-1:0] rd;
  logic          ren;

  function automatic logic [DW-1:0] rand_duty();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return DW'($urandom_range(0, (1 << DW) - 1));
    endcase
  endfunction

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    mode   = '0;
    duty   = '0;
    model_reset();
    repeat (3) @(negedge pin3_clk_16mhz);
    check("reset_led", 32'(led), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    rst_n = 1'b1;

    // Prescaler only: four ticks in sixteen clocks, LEDs dark
    tick_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 4'b0000, 8'h00);
      if (tick) tick_cnt++;
    end
    check("tick_count", 32'(tick_cnt), 32'd4);

    // ch0 DIM at 4, 0, 15
    run(32, 1'b1, 4'b0001, 8'h04);
    run(16, 1'b1, 4'b0001, 8'h00);
    run(16, 1'b1, 4'b0001, 8'h0F);

    // ch1 BLINK full duty alongside ch0 DIM, then a DIM detour in the off phase
    run(42, 1'b1, 4'b1001, 8'hF4);
    run(1,  1'b1, 4'b0101, 8'hF4);
    run(30, 1'b1, 4'b1001, 8'hF4);

    // Freeze, resume
    run(10, 1'b0, 4'b1001, 8'hF4);
    run(30, 1'b1, 4'b1001, 8'hF4);

    // ch0 breathe (DIM-equivalent without the macro)
    run(64, 1'b1, 4'b1011, 8'hF3);

    // Randomized traffic; breathe channels keep duty until they change mode
    rm = mode;
    rd = duty;
    for (int k = 0; k < 3000; k++) begin
      ren = ($urandom_range(0, 19) != 0);
      for (int c = 0; c < CH; c++) begin
        case ($urandom_range(0, 23))
          0: begin
            rm[2*c +: 2]  = rm[2*c +: 2] + 2'($urandom_range(1, 3));
            rd[DW*c +: DW] = rand_duty();
          end
          1: begin
`ifdef LED_PATTERN_BREATHE_EN
            if (rm[2*c +: 2] != 2'b11) rd[DW*c +: DW] = rand_duty();
`else
            rd[DW*c +: DW] = rand_duty();
`endif
          end
          default: ;
        endcase
      end
      step(ren, rm, rd);
    end

    // Async reset mid-run while ch0 is fully lit
    run(8, 1'b1, 4'b0001, 8'h0F);
    rst_n = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'h0);
    check("arst_tick", 32'(tick), 32'h0);
    @(negedge pin3_clk_16mhz);
    model_reset();
    rst_n = 1'b1;
    run(40, 1'b1, 4'b1001, 8'hF7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
